// File: rtl/fetch_align_if.sv
// Handshake bundle between the fetch port, the aligner and the decompressor.
interface fetch_align_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic        instr_is_rvc;
    logic [31:0] instr_pc;

    // Surrounding core: supplies fetch words and redirects, consumes instructions.
    modport master (
        output fetch_valid, fetch_data, flush, flush_pc, instr_ready,
        input  fetch_ready, instr_valid, instr_data, instr_is_rvc, instr_pc
    );

    // Aligner side.
    modport slave (
        input  fetch_valid, fetch_data, flush, flush_pc, instr_ready,
        output fetch_ready, instr_valid, instr_data, instr_is_rvc, instr_pc
    );
endinterface

// File: rtl/fetch_align.sv
// Halfword realignment buffer: splits word-aligned fetch words into a circular
// halfword queue and emits one 16-bit or 32-bit instruction per handshake,
// tracking the PC of the queue head.
module fetch_align #(
    parameter logic [31:0] RESETVEC = 32'h0,
    parameter int unsigned QDEPTH   = 4
) (
    input logic          clk,
    input logic          reset,
    fetch_align_if.slave bus
);
    localparam int unsigned  PW      = $clog2(QDEPTH);
    localparam int unsigned  CW      = $clog2(QDEPTH + 1);
    localparam logic [PW:0]  DEPTH_P = (PW + 1)'(QDEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
    localparam logic [CW-1:0] PUSH_TH = CW'(QDEPTH - 2);

    logic [15:0]    mem_q [QDEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, wr_ptr_n1;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    head_pc_q, head_pc_d;
    logic           drop_lo_q, drop_lo_d;

    logic [15:0]    hw0, hw1;
    logic           hw0_rvc;
    logic           fetch_ready_c, instr_valid_c;
    logic           push, pop;
    logic [1:0]     push_n, pop_n;

    // Pointer advance with wrap at QDEPTH (QDEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + (PW + 1)'(n);
        if (s >= DEPTH_P) s = s - DEPTH_P;
        return s[PW-1:0];
    endfunction

    // Output decode, handshake qualification and next-state computation.
    always_comb begin
        hw0           = mem_q[rd_ptr_q];
        hw1           = mem_q[ptr_add(rd_ptr_q, 2'd1)];
        hw0_rvc       = (hw0[1:0] != 2'b11);
        fetch_ready_c = !bus.flush && (count_q <= PUSH_TH);
        instr_valid_c = !bus.flush && (count_q != '0) && (hw0_rvc || (count_q >= CW'(2)));

        bus.fetch_ready  = fetch_ready_c;
        bus.instr_valid  = instr_valid_c;
        bus.instr_is_rvc = instr_valid_c && hw0_rvc;
        bus.instr_pc     = head_pc_q;
        bus.instr_data   = '0;
        if (instr_valid_c) begin
            bus.instr_data = hw0_rvc ? {16'h0, hw0} : {hw1, hw0};
        end

        push      = bus.fetch_valid && fetch_ready_c;
        pop       = instr_valid_c && bus.instr_ready;
        push_n    = push ? (drop_lo_q ? 2'd1 : 2'd2) : 2'd0;
        pop_n     = pop ? (hw0_rvc ? 2'd1 : 2'd2) : 2'd0;
        wr_ptr_n1 = ptr_add(wr_ptr_q, 2'd1);

        rd_ptr_d  = ptr_add(rd_ptr_q, pop_n);
        wr_ptr_d  = ptr_add(wr_ptr_q, push_n);
        count_d   = count_q + CW'(push_n) - CW'(pop_n);
        head_pc_d = head_pc_q + {29'b0, pop_n, 1'b0};
        drop_lo_d = drop_lo_q && !push;

        // Flush gates both handshakes above, so only the redirect state matters here.
        if (bus.flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            head_pc_d = bus.flush_pc & ~32'h1;
            drop_lo_d = bus.flush_pc[1];
        end
    end

    // Control state: pointers, occupancy, head PC and pending low-half drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_pc_q <= RESETVEC;
            drop_lo_q <= RESETVEC[1];
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            drop_lo_q <= drop_lo_d;
        end
    end

    // Halfword storage: lower halfword first unless a redirect landed mid-word.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            if (drop_lo_q) begin
                mem_q[wr_ptr_q] <= bus.fetch_data[31:16];
            end else begin
                mem_q[wr_ptr_q]  <= bus.fetch_data[15:0];
                mem_q[wr_ptr_n1] <= bus.fetch_data[31:16];
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= DEPTH_C);
endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align: directed scenarios plus a randomized
// run compared against a halfword-queue reference model.
module tb_fetch_align;
    localparam logic [31:0] RESETVEC = 32'h0;
    localparam int          QDEPTH   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_align_if bus ();

    fetch_align #(.RESETVEC(RESETVEC), .QDEPTH(QDEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queue of halfwords, head PC, pending low-half drop.
    logic [15:0] mq[$];
    logic [31:0] m_pc   = RESETVEC;
    logic        m_drop = RESETVEC[1];
    logic        e_valid, e_rvc, e_fready;
    logic [31:0] e_data, e_pc;

    function automatic void model_eval();
        logic [15:0] h0, h1;
        logic        h0_rvc;
        h0 = (mq.size() > 0) ? mq[0] : 16'h0;
        h1 = (mq.size() > 1) ? mq[1] : 16'h0;
        h0_rvc   = (h0[1:0] != 2'b11);
        e_valid  = !bus.flush && (mq.size() >= 1) && (h0_rvc || mq.size() >= 2);
        e_rvc    = e_valid && h0_rvc;
        e_data   = !e_valid ? 32'h0 : (h0_rvc ? {16'h0, h0} : {h1, h0});
        e_fready = !bus.flush && (mq.size() <= QDEPTH - 2);
        e_pc     = m_pc;
    endfunction

    // Advance model by one clock using current inputs, then move past the edge.
    task automatic tick();
        model_eval();
        if (reset) begin
            mq.delete();
            m_pc   = RESETVEC;
            m_drop = RESETVEC[1];
        end else if (bus.flush) begin
            mq.delete();
            m_pc   = {bus.flush_pc[31:1], 1'b0};
            m_drop = bus.flush_pc[1];
        end else begin
            if (e_valid && bus.instr_ready) begin
                void'(mq.pop_front());
                if (e_rvc) m_pc = m_pc + 32'd2;
                else begin
                    void'(mq.pop_front());
                    m_pc = m_pc + 32'd4;
                end
            end
            if (bus.fetch_valid && e_fready) begin
                if (!m_drop) mq.push_back(bus.fetch_data[15:0]);
                mq.push_back(bus.fetch_data[31:16]);
                m_drop = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [65:0] observe();
        return {bus.instr_valid, bus.instr_is_rvc, bus.instr_pc, bus.instr_data};
    endfunction

    function automatic string fmt(input logic [65:0] o);
        return $sformatf("v=%b rvc=%b pc=%h data=%h", o[65], o[64], o[63:32], o[31:0]);
    endfunction

    function automatic logic [15:0] rand_rvc_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if (h[1:0] == 2'b11) h[1:0] = 2'b00;
        return h;
    endfunction

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = rand_rvc_hw();
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    task automatic idle_inputs();
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = 32'h0;
        bus.flush       = 1'b0;
        bus.flush_pc    = 32'h0;
        bus.instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [65:0] exp_o;
        do_reset();
        exp_o = {1'b0, 1'b0, RESETVEC, 32'h0};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL reset_outputs: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        n_checks++;
        if (bus.fetch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fetch_ready: got %b exp 1", bus.fetch_ready);
        end
    endtask

    task automatic test_single32();
        logic [65:0] exp_o;
        do_reset();
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h0000_0513;
        #1;
        tick();
        bus.fetch_valid = 1'b0;
        #1;
        exp_o = {1'b1, 1'b0, 32'h0, 32'h0000_0513};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL single32_out: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        bus.instr_ready = 1'b1;
        #1;
        tick();
        exp_o = {1'b0, 1'b0, 32'h4, 32'h0};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL single32_drained: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
    endtask

    task automatic test_compressed_pair();
        logic [65:0] exp_o;
        do_reset();
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h4005_4501;
        bus.instr_ready = 1'b1;
        #1;
        tick();
        bus.fetch_valid = 1'b0;
        #1;
        exp_o = {1'b1, 1'b1, 32'h0, 32'h0000_4501};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL pair_first: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        tick();
        exp_o = {1'b1, 1'b1, 32'h2, 32'h0000_4005};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL pair_second: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        tick();
        exp_o = {1'b0, 1'b0, 32'h4, 32'h0};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL pair_empty: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
    endtask

    task automatic test_spanning();
        logic [65:0] exp_o;
        do_reset();
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h0513_4501;
        bus.instr_ready = 1'b1;
        #1;
        tick();
        bus.fetch_valid = 1'b0;
        #1;
        exp_o = {1'b1, 1'b1, 32'h0, 32'h0000_4501};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL span_rvc: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        tick();
        exp_o = {1'b0, 1'b0, 32'h2, 32'h0};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL span_wait: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h0001_0000;
        #1;
        tick();
        bus.fetch_valid = 1'b0;
        #1;
        exp_o = {1'b1, 1'b0, 32'h2, 32'h0000_0513};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL span_32: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        tick();
        exp_o = {1'b1, 1'b1, 32'h6, 32'h0000_0001};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL span_tail: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
    endtask

    task automatic test_flush();
        logic [65:0] exp_o;
        do_reset();
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h0000_0513;
        #1;
        tick();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_0103;
        bus.fetch_data = 32'hdead_4501;
        #1;
        n_checks++;
        if (bus.fetch_ready !== 1'b0 || bus.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: got fetch_ready=%b instr_valid=%b exp 0 0",
                     bus.fetch_ready, bus.instr_valid);
        end
        tick();
        bus.flush       = 1'b0;
        bus.fetch_data  = 32'h0001_4501;
        #1;
        exp_o = {1'b0, 1'b0, 32'h102, 32'h0};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL flush_target: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        tick();
        bus.fetch_valid = 1'b0;
        #1;
        exp_o = {1'b1, 1'b1, 32'h102, 32'h0000_0001};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL flush_drop_lo: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        bus.instr_ready = 1'b1;
        #1;
        tick();
        exp_o = {1'b0, 1'b0, 32'h104, 32'h0};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL flush_single: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_hw[$];
        logic [31:0] exp_pc;
        logic [31:0] w;
        bit          first;
        do_reset();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_0002;
        #1;
        tick();
        bus.flush = 1'b0;
        first  = 1'b1;
        exp_pc = 32'h2;
        for (int i = 0; i < 4; i++) begin
            w = {rand_rvc_hw(), rand_rvc_hw()};
            bus.fetch_valid = 1'b1;
            bus.fetch_data  = w;
            #1;
            model_eval();
            n_checks++;
            if (bus.fetch_ready !== e_fready || bus.instr_valid !== e_valid) begin
                n_fail++;
                $display("FAIL bp_fill[%0d]: got fetch_ready=%b instr_valid=%b exp %b %b",
                         i, bus.fetch_ready, bus.instr_valid, e_fready, e_valid);
            end
            if (e_fready) begin
                if (!first) exp_hw.push_back(w[15:0]);
                exp_hw.push_back(w[31:16]);
                first = 1'b0;
            end
            tick();
        end
        n_checks++;
        if (bus.fetch_ready !== 1'b0 || exp_hw.size() != 3) begin
            n_fail++;
            $display("FAIL bp_full: got fetch_ready=%b queued=%0d exp 0 3",
                     bus.fetch_ready, exp_hw.size());
        end
        bus.fetch_valid = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.instr_valid === 1'b1) begin
                n_checks++;
                if (exp_hw.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: got data=%h pc=%h exp none", bus.instr_data, bus.instr_pc);
                end else if (bus.instr_data !== {16'h0, exp_hw[0]} || bus.instr_pc !== exp_pc ||
                             bus.instr_is_rvc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_drain: got data=%h pc=%h rvc=%b exp data=%h pc=%h rvc=1",
                             bus.instr_data, bus.instr_pc, bus.instr_is_rvc, exp_hw[0], exp_pc);
                end
                if (exp_hw.size() != 0) void'(exp_hw.pop_front());
                exp_pc = exp_pc + 32'd2;
            end
            tick();
        end
        n_checks++;
        if (exp_hw.size() != 0 || bus.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_all_emitted: got left=%0d valid=%b exp 0 0", exp_hw.size(), bus.instr_valid);
        end
    endtask

    task automatic test_reset_and_flush_priority();
        logic [65:0] exp_o;
        do_reset();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_0002;
        #1;
        tick();
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h4111_4222;
        #1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        #1;
        exp_o = {1'b0, 1'b0, RESETVEC, 32'h0};
        n_checks++;
        if (observe() !== exp_o || bus.fetch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset: got %s frdy=%b exp %s frdy=1", fmt(observe()), bus.fetch_ready, fmt(exp_o));
        end
        bus.fetch_data = 32'h0000_0513;
        #1;
        tick();
        bus.fetch_valid = 1'b0;
        #1;
        exp_o = {1'b1, 1'b0, RESETVEC, 32'h0000_0513};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL midreset_clean: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
        bus.instr_ready = 1'b1;
        bus.flush       = 1'b1;
        bus.flush_pc    = 32'h0000_0200;
        #1;
        n_checks++;
        if (bus.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flushpop_valid: got %b exp 0", bus.instr_valid);
        end
        tick();
        bus.flush = 1'b0;
        #1;
        exp_o = {1'b0, 1'b0, 32'h200, 32'h0};
        n_checks++;
        if (observe() !== exp_o) begin
            n_fail++;
            $display("FAIL flushpop_pc: got %s exp %s", fmt(observe()), fmt(exp_o));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.fetch_valid = ($urandom_range(0, 3) != 0);
            bus.fetch_data  = {rand_hw(), rand_hw()};
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 39) == 0);
            bus.flush_pc    = $urandom;
            reset           = ($urandom_range(0, 199) == 0);
            #1;
            model_eval();
            n_checks++;
            if (bus.instr_valid !== e_valid || bus.instr_is_rvc !== e_rvc || bus.fetch_ready !== e_fready ||
                bus.instr_pc !== e_pc || bus.instr_data !== e_data) begin
                n_fail++;
                $display("FAIL random cyc %0d: got v=%b rvc=%b frdy=%b pc=%h data=%h exp v=%b rvc=%b frdy=%b pc=%h data=%h",
                         cyc, bus.instr_valid, bus.instr_is_rvc, bus.fetch_ready, bus.instr_pc, bus.instr_data,
                         e_valid, e_rvc, e_fready, e_pc, e_data);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single32();
        test_compressed_pair();
        test_spanning();
        test_flush();
        test_backpressure();
        test_reset_and_flush_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
